// File: rtl/eh2_posit_mul_pipe.sv
// Pipelined posit multiplier on decoded fields (sign, regime, exponent, fraction) with valid/ready stages.
// Optional saturation of out-of-range scales is enabled by defining POSIT_MUL_SAT_EN.
module eh2_posit_mul_pipe #(
    parameter int POSIT_LEN   = 32,
    parameter int ES          = 3,
    parameter int REGIME_BW   = $clog2(POSIT_LEN),
    parameter int FRACTION_BW = POSIT_LEN - ES - 3,
    parameter int FRAC_W_GRS  = POSIT_LEN - ES,
    parameter int MAX_REG     = POSIT_LEN - 1,
    parameter int STAGES      = 2,
    parameter int TAG_W       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   a_sgn,
    input  logic                   b_sgn,
    input  logic [REGIME_BW-1:0]   a_reg,
    input  logic [REGIME_BW-1:0]   b_reg,
    input  logic [ES-1:0]          a_exp,
    input  logic [ES-1:0]          b_exp,
    input  logic [FRACTION_BW-1:0] a_fra,
    input  logic [FRACTION_BW-1:0] b_fra,
    input  logic                   a_zero,
    input  logic                   b_zero,
    input  logic                   a_nar,
    input  logic                   b_nar,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_sgn,
    output logic [REGIME_BW-1:0]   out_reg,
    output logic [ES-1:0]          out_exp,
    output logic [FRAC_W_GRS-1:0]  out_fra,
    output logic                   out_zero,
    output logic                   out_nar,
    output logic                   out_oflw_uflw
);

    localparam int PW = 2 * (FRACTION_BW + 1);
    localparam int SW = REGIME_BW + ES + 1;
    localparam int TW = REGIME_BW + 1;
    localparam int unsigned NS = STAGES;
    localparam logic signed [TW:0] MAX_S = (TW + 1)'(MAX_REG);

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic                  sgn;
        logic [REGIME_BW-1:0]  rg;
        logic [ES-1:0]         ex;
        logic [FRAC_W_GRS-1:0] fra;
        logic                  zero;
        logic                  nar;
        logic                  oflw;
    } slot_t;

    logic [PW-1:0]        prod;
    logic [PW-2:0]        prod_n;
    logic                 carry;
    logic [SW-1:0]        scale;
    logic [TW-1:0]        t;
    logic signed [TW:0]   t_ext;
    logic signed [TW:0]   t_neg;
    slot_t                res;

    always_comb begin
        prod  = PW'({1'b1, a_fra}) * PW'({1'b1, b_fra});
        carry = prod[PW-1];
        // Drop the hidden one so the retained field always starts at the top bit
        prod_n = carry ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        scale = {a_reg[REGIME_BW-1], a_reg, a_exp} + {b_reg[REGIME_BW-1], b_reg, b_exp}
              + {{(SW-1){1'b0}}, carry};
        t     = scale[SW-1:ES];
        t_ext = {t[TW-1], t};
        t_neg = -t_ext;

        res      = '0;
        res.tag  = in_tag;
        res.sgn  = a_sgn ^ b_sgn;
        res.rg   = t[REGIME_BW-1:0];
        res.ex   = scale[ES-1:0];
        res.fra  = {prod_n[PW-2:FRACTION_BW-1], |prod_n[FRACTION_BW-2:0]};
        res.oflw = (t_ext >= MAX_S) | (t_neg > MAX_S);
`ifdef POSIT_MUL_SAT_EN
        if (res.oflw) begin
            if (!t[TW-1]) begin
                res.rg  = REGIME_BW'(MAX_REG - 1);
                res.ex  = '1;
                res.fra = '1;
            end else begin
                res.rg  = REGIME_BW'(-(MAX_REG - 1));
                res.ex  = '0;
                res.fra = '0;
            end
        end
`endif
        if (a_nar | b_nar | a_zero | b_zero) begin
            res.sgn  = 1'b0;
            res.rg   = '0;
            res.ex   = '0;
            res.fra  = '0;
            res.oflw = 1'b0;
            res.nar  = a_nar | b_nar;
            res.zero = !(a_nar | b_nar);
        end
    end

    slot_t          data [STAGES];
    logic [NS-1:0]  vld;
    logic [NS-1:0]  adv;
    logic [NS-1:0]  load;
    logic           hole;

    // A slot advances if the output drains or any later slot is empty
    always_comb begin
        adv  = '0;
        hole = 1'b0;
        for (int unsigned i = 0; i < NS; i++) begin
            hole = out_ready;
            for (int unsigned j = i + 1; j < NS; j++) begin
                hole = hole | !vld[j];
            end
            adv[i] = vld[i] & hole;
        end
    end

    assign in_ready = !rst & !flush & (!vld[0] | adv[0]);

    always_comb begin
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int unsigned i = 1; i < NS; i++) begin
            load[i] = adv[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < NS; i++) begin
                data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NS; i++) begin
                vld[i] <= flush ? 1'b0 : (load[i] | (vld[i] & !adv[i]));
            end
            if (load[0]) data[0] <= res;
            for (int unsigned i = 1; i < NS; i++) begin
                if (load[i]) data[i] <= data[i-1];
            end
        end
    end

    assign out_valid     = vld[NS-1];
    assign out_tag       = data[NS-1].tag;
    assign out_sgn       = data[NS-1].sgn;
    assign out_reg       = data[NS-1].rg;
    assign out_exp       = data[NS-1].ex;
    assign out_fra       = data[NS-1].fra;
    assign out_zero      = data[NS-1].zero;
    assign out_nar       = data[NS-1].nar;
    assign out_oflw_uflw = data[NS-1].oflw;

endmodule

// File: doc/eh2_posit_mul_pipe.md
# eh2_posit_mul_pipe

Pipelined, parametrised posit multiplier core operating on decoded posit fields (sign, signed regime, exponent, fraction) in the EXU posit datapath. It sits between the posit decoder and the posit rounding/encoding stage. It adds a configurable pipeline depth, per-stage valid/ready backpressure, tag passthrough, flush, zero/NaR handling and a full-width sticky bit.

## Interface
- POSIT_LEN, 32, posit width
- ES, 3, exponent bits
- REGIME_BW, $clog2(POSIT_LEN), signed regime field width
- FRACTION_BW, POSIT_LEN-ES-3, input fraction bits (hidden 1 excluded)
- FRAC_W_GRS, POSIT_LEN-ES, output fraction width including guard/round/sticky
- MAX_REG, POSIT_LEN-1, regime magnitude limit
- STAGES, 2, pipeline register stages, legal 1..4
- TAG_W, 5, opaque tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  drop all in-flight ops
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_tag  in  TAG_W  carried to output unchanged
- a_sgn, b_sgn  in  1  operand signs
- a_reg, b_reg  in  REGIME_BW  two's-complement regimes
- a_exp, b_exp  in  ES  exponents
- a_fra, b_fra  in  FRACTION_BW  fractions
- a_zero, b_zero, a_nar, b_nar  in  1  special-value flags
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_tag  out  TAG_W
- out_sgn  out  1
- out_reg  out  REGIME_BW
- out_exp  out  ES
- out_fra  out  FRAC_W_GRS
- out_zero, out_nar  out  1
- out_oflw_uflw  out  1  scale out of range

## Operation
- Sign: a_sgn ^ b_sgn.
- Mantissa product P = {1,a_fra} x {1,b_fra}, unsigned, 2*(FRACTION_BW+1) bits; C = P MSB.
- Scale: signed {reg,exp} of A plus signed {reg,exp} of B plus C, result REGIME_BW+ES+1 bits. The low ES bits give out_exp. The upper REGIME_BW+1 bits form T. out_reg = T[REGIME_BW-1:0].
- out_oflw_uflw = (signed T >= MAX_REG) | (-T > MAX_REG).
- out_fra, C=1: P[MSB-1 : FRACTION_BW-1], then sticky.
- out_fra, C=0: P[MSB-2 : FRACTION_BW-2], then sticky.
- Sticky is the OR of all P bits below the retained field.
- Special values: if either NaR flag is set, out_nar=1.
- Otherwise, if either zero flag is set, out_zero=1.
- In both special cases out_reg, out_exp, out_fra and out_oflw_uflw are all 0, and out_sgn=0.
- Pipeline: STAGES registered slots, each with its own valid bit. A slot advances when the next slot is empty or is advancing. Bubbles collapse.
- in_ready = !rst & !flush & (slot 0 empty or advancing).
- Order and tags are preserved. Sustained throughput is 1 op/cycle.
- Output data must not change while out_valid=1 and out_ready=0.
- flush clears all valid bits at the next edge. No input is accepted during a flush cycle. Outputs present during a flush cycle are still consumed if out_ready=1.

## Timing
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following N+STAGES-1, provided there is no stall.
- Pipeline capacity: STAGES ops.
- Reset (asynchronous): all valid bits 0 and all output data 0. in_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation discards every in-flight op. No output handshake occurs for a discarded op.
- Simultaneous accept and emit at a full pipe is legal; occupancy is unchanged.

## Configuration
- POSIT_MUL_SAT_EN defined, with out_oflw_uflw=1 and T>=0:
  - out_reg = MAX_REG-1
  - out_exp all ones
  - out_fra all ones
- POSIT_MUL_SAT_EN defined, with out_oflw_uflw=1 and T<0:
  - out_reg = -(MAX_REG-1) in two's complement
  - out_exp = 0
  - out_fra = 0
- In both saturation cases out_oflw_uflw stays 1.
- POSIT_MUL_SAT_EN not defined: the fields pass unsaturated, as computed above.

## Test plan
- 1.0 x 1.0: all fields 0, signs 0/1 -> out_sgn=1, out_reg=0, out_exp=0, out_fra=0, flag 0, out_valid exactly STAGES cycles after acceptance.
- 1.5 x 1.5: a_fra=b_fra=26'h2000000 -> C=1, out_exp=1, out_reg=0, out_fra=29'h04000000, sticky 0.
- Overflow: reg=15, exp=7 on both operands -> T=31, out_exp=6, flag=1. With POSIT_MUL_SAT_EN: out_reg=30, out_exp=7, out_fra all ones.
- Backpressure, STAGES=2: out_ready=0, issue tags 1..4 -> in_ready drops after 2 accepts. Then release out_ready -> tags emerge 1,2,3,4 with stable data while stalled.
- Flush with 2 ops in flight -> no out_valid for them. Next op (tag 9) emerges with normal latency.
- NaR/zero: a_nar=1, b_zero=1 -> out_nar=1, out_zero=0, all fields 0. Assert rst mid-stream -> out_valid=0 immediately, with no stale outputs after release.
